// File: rtl/stereo_frame_source.sv
// Stereo AXI4-Stream test-pattern source: left and right streams share one handshake,
// and the right image is the left pattern shifted by DISPARITY pixels, clamped at the line end.
module stereo_frame_source #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int BPP       = 8,
    parameter int NPPC      = 4,
    parameter int HBLANK    = 16,
    parameter int VBLANK    = 64,
    parameter int DISPARITY = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    output logic                  m_axis_l_tvalid,
    output logic                  m_axis_l_tlast,
    output logic                  m_axis_l_tuser,
    output logic [BPP*NPPC-1:0]   m_axis_l_tdata,
    input  logic                  m_axis_l_tready,
    output logic                  m_axis_r_tvalid,
    output logic                  m_axis_r_tlast,
    output logic                  m_axis_r_tuser,
    output logic [BPP*NPPC-1:0]   m_axis_r_tdata,
    input  logic                  m_axis_r_tready,
    output logic [7:0]            frame_cnt,
    output logic                  frame_done
);

    localparam int BEATS     = WIDTH / NPPC;
    localparam int DW        = BPP * NPPC;
    localparam int XW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int BW        = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(BEATS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [BW-1:0] HB_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [BW-1:0] VB_LAST = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    state_t          state, state_d;
    logic [XW-1:0]   x_beat, x_beat_d;
    logic [YW-1:0]   y, y_d;
    logic [BW-1:0]   blank_cnt, blank_d;
    logic [1:0]      pat, pat_d;
    logic [7:0]      frame_cnt_d;
    logic            frame_done_d;
    logic            tvalid, tvalid_d, tlast, tlast_d, tuser, tuser_d;
    logic [DW-1:0]   l_data, l_data_d, r_data, r_data_d;
    logic            beat_accept;

    assign beat_accept = tvalid & m_axis_l_tready & m_axis_r_tready;

    function automatic logic [BPP-1:0] pattern_pixel(input logic [1:0] sel, input logic [31:0] px,
                                                     input logic [31:0] py, input logic [7:0] fc);
        logic [31:0] sum;
        sum = px + py + {24'd0, fc};
        case (sel)
            2'd0:    pattern_pixel = px[BPP-1:0];
            2'd1:    pattern_pixel = py[BPP-1:0];
            2'd2:    pattern_pixel = (px[3] ^ py[3]) ? '1 : '0;
            default: pattern_pixel = sum[BPP-1:0];
        endcase
    endfunction

    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (!aresetn) begin
            state      <= S_IDLE;
            x_beat     <= '0;
            y          <= '0;
            blank_cnt  <= '0;
            pat        <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            tvalid     <= 1'b0;
            tlast      <= 1'b0;
            tuser      <= 1'b0;
            l_data     <= '0;
            r_data     <= '0;
        end else begin
            state      <= state_d;
            x_beat     <= x_beat_d;
            y          <= y_d;
            blank_cnt  <= blank_d;
            pat        <= pat_d;
            frame_cnt  <= frame_cnt_d;
            frame_done <= frame_done_d;
            tvalid     <= tvalid_d;
            tlast      <= tlast_d;
            tuser      <= tuser_d;
            l_data     <= l_data_d;
            r_data     <= r_data_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
        state_d      = state;
        x_beat_d     = x_beat;
        y_d          = y;
        blank_d      = blank_cnt;
        pat_d        = pat;
        frame_cnt_d  = frame_cnt;
        frame_done_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_ACTIVE;
                    x_beat_d = '0;
                    y_d      = '0;
                    pat_d    = pattern_sel;
                end
            end
            S_ACTIVE: begin
                if (beat_accept) begin
                    if (x_beat != X_LAST) begin
                        x_beat_d = x_beat + XW'(1);
                    end else begin
                        x_beat_d = '0;
                        blank_d  = '0;
                        if (y != Y_LAST) begin
                            y_d     = y + YW'(1);
                            state_d = (HBLANK == 0) ? S_ACTIVE : S_HBLANK;
                        end else begin
                            y_d          = '0;
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt + 8'd1;
                            state_d      = (VBLANK == 0) ? S_IDLE : S_VBLANK;
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (blank_cnt == HB_LAST) state_d = S_ACTIVE;
                else                      blank_d = blank_cnt + BW'(1);
            end
            default: begin
                if (blank_cnt == VB_LAST) state_d = S_IDLE;
                else                      blank_d = blank_cnt + BW'(1);
            end
        endcase
    end

    // Outputs are precomputed from the next state; a stalled beat recomputes to identical values.
    always_comb begin
        int xl;
        int xr;
        xl       = 0;
        xr       = 0;
        tvalid_d = (state_d == S_ACTIVE);
        tlast_d  = tvalid_d && (x_beat_d == X_LAST);
        tuser_d  = tvalid_d && (x_beat_d == '0) && (y_d == '0);
        l_data_d = '0;
        r_data_d = '0;
        if (tvalid_d) begin
            for (int i = 0; i < NPPC; i++) begin
                xl = int'(x_beat_d) * NPPC + i;
                xr = (xl + DISPARITY > WIDTH - 1) ? WIDTH - 1 : xl + DISPARITY;
                l_data_d[i*BPP +: BPP] = pattern_pixel(pat_d, xl, 32'(y_d), frame_cnt_d);
                r_data_d[i*BPP +: BPP] = pattern_pixel(pat_d, xr, 32'(y_d), frame_cnt_d);
            end
        end
    end

    assign m_axis_l_tvalid = tvalid;
    assign m_axis_r_tvalid = tvalid;
    assign m_axis_l_tlast  = tlast;
    assign m_axis_r_tlast  = tlast;
    assign m_axis_l_tuser  = tuser;
    assign m_axis_r_tuser  = tuser;
    assign m_axis_l_tdata  = l_data;
    assign m_axis_r_tdata  = r_data;

endmodule

// File: tb/tb_stereo_frame_source.sv
// Bench for stereo_frame_source: a small instance for protocol/pattern scenarios and a
// full-size checkerboard instance running in parallel.
module tb_stereo_frame_source;

    localparam int W = 16, H = 4, HB = 2, VB = 3, DS = 2;
    localparam int BEATS = W / 4;
    localparam int FB = BEATS * H;
    localparam int BIG_W = 640, BIG_H = 480, BIG_DS = 8;
    localparam int BIG_BEATS = BIG_W / 4;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic        last;
        logic        user;
        int          cyc;
    } beat_t;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn = 1'b0, enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        l_tvalid, l_tlast, l_tuser, r_tvalid, r_tlast, r_tuser;
    logic        l_tready = 1'b1, r_tready = 1'b1;
    logic [31:0] l_tdata, r_tdata;
    logic [7:0]  frame_cnt;
    logic        frame_done;

    logic        b_rstn = 1'b0, b_en = 1'b0;
    logic        b_l_tvalid, b_l_tlast, b_l_tuser, b_r_tvalid, b_r_tlast, b_r_tuser;
    logic        b_ready = 1'b1;
    logic [31:0] b_l_tdata, b_r_tdata;
    logic [7:0]  b_frame_cnt;
    logic        b_frame_done;

    stereo_frame_source #(.WIDTH(W), .HEIGHT(H), .BPP(8), .NPPC(4), .HBLANK(HB), .VBLANK(VB),
                          .DISPARITY(DS)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .pattern_sel(pattern_sel),
        .m_axis_l_tvalid(l_tvalid), .m_axis_l_tlast(l_tlast), .m_axis_l_tuser(l_tuser),
        .m_axis_l_tdata(l_tdata), .m_axis_l_tready(l_tready),
        .m_axis_r_tvalid(r_tvalid), .m_axis_r_tlast(r_tlast), .m_axis_r_tuser(r_tuser),
        .m_axis_r_tdata(r_tdata), .m_axis_r_tready(r_tready),
        .frame_cnt(frame_cnt), .frame_done(frame_done)
    );

    stereo_frame_source #(.WIDTH(BIG_W), .HEIGHT(BIG_H), .BPP(8), .NPPC(4), .HBLANK(0), .VBLANK(0),
                          .DISPARITY(BIG_DS)) dut_big (
        .aclk(aclk), .aresetn(b_rstn), .enable(b_en), .pattern_sel(2'd2),
        .m_axis_l_tvalid(b_l_tvalid), .m_axis_l_tlast(b_l_tlast), .m_axis_l_tuser(b_l_tuser),
        .m_axis_l_tdata(b_l_tdata), .m_axis_l_tready(b_ready),
        .m_axis_r_tvalid(b_r_tvalid), .m_axis_r_tlast(b_r_tlast), .m_axis_r_tuser(b_r_tuser),
        .m_axis_r_tdata(b_r_tdata), .m_axis_r_tready(b_ready),
        .frame_cnt(b_frame_cnt), .frame_done(b_frame_done)
    );

    int    n_tests = 0, n_fail = 0;
    int    cyc = 0;
    int    acc_idx = 0, beat_err = 0, stall_err = 0, done_cnt = 0, done_cyc = 0;
    int    exp_pat = 0;
    beat_t acc_q[$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference pattern from the pixel rules, independent of how the design sequences beats.
    function automatic logic [7:0] pix(int pat, int x, int y, int fc);
        int v;
        case (pat)
            0:       v = x;
            1:       v = y;
            2:       v = ((((x / 8) ^ (y / 8)) % 2) == 1) ? 255 : 0;
            default: v = x + y + fc;
        endcase
        return 8'(v % 256);
    endfunction

    function automatic logic [31:0] exp_beat(int pat, int fc, int y, int k, bit right, int w, int d);
        logic [31:0] data;
        int x;
        data = '0;
        for (int i = 0; i < 4; i++) begin
            x = k * 4 + i;
            if (right) x = (x + d > w - 1) ? w - 1 : x + d;
            data[i*8 +: 8] = pix(pat, x, y, fc);
        end
        return data;
    endfunction

    // Small-instance monitor: scores every accepted beat and checks the hold rule while stalled.
    initial begin
        logic [31:0] pl, pr, el, er;
        logic        plast, puser;
        bit          held;
        int          f, b, yy, kk;
        held = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                acc_idx = 0;
                held = 0;
            end else begin
                if (l_tvalid !== r_tvalid) stall_err++;
                if (held && (!l_tvalid || l_tdata !== pl || r_tdata !== pr ||
                             l_tlast !== plast || l_tuser !== puser)) stall_err++;
                held = 0;
                if (l_tvalid) begin
                    if (l_tready && r_tready) begin
                        f  = acc_idx / FB;
                        b  = acc_idx % FB;
                        yy = b / BEATS;
                        kk = b % BEATS;
                        el = exp_beat(exp_pat, f % 256, yy, kk, 0, W, DS);
                        er = exp_beat(exp_pat, f % 256, yy, kk, 1, W, DS);
                        if (l_tdata !== el || r_tdata !== er || l_tlast !== (kk == BEATS - 1) ||
                            l_tuser !== (b == 0) || r_tlast !== l_tlast || r_tuser !== l_tuser)
                            beat_err++;
                        acc_q.push_back('{l: l_tdata, r: r_tdata, last: l_tlast, user: l_tuser, cyc: cyc});
                        acc_idx++;
                    end else begin
                        pl = l_tdata; pr = r_tdata; plast = l_tlast; puser = l_tuser;
                        held = 1;
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic do_reset();
        aresetn = 1'b0;
        enable = 1'b0;
        l_tready = 1'b1;
        r_tready = 1'b1;
        tick();
        tick();
        aresetn = 1'b1;
        acc_q.delete();
        beat_err = 0;
        stall_err = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, done_cnt >= target, 1);
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int n = 0;
        while (acc_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, acc_q.size() >= target, 1);
    endtask

    task automatic small_seq();
        int n, pat, pat2, n0, valid_seen;
        logic [15:0] last_mask;
        int users;

        // Reset state (enable high must not matter while in reset), then one pattern-0 frame.
        aresetn = 1'b0; enable = 1'b1; exp_pat = 0; pattern_sel = 2'd0;
        tick(); tick();
        check("rst_tvalid", {l_tvalid, r_tvalid}, 0);
        check("rst_tdata", {l_tdata, r_tdata}, 0);
        check("rst_flags", {l_tlast, l_tuser, r_tlast, r_tuser, frame_done}, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        aresetn = 1'b1; acc_q.delete(); beat_err = 0; stall_err = 0; done_cnt = 0;
        tick();
        check("s1_first_tvalid", l_tvalid, 1);
        check("s1_first_tdata", l_tdata, 32'h03020100);
        enable = 1'b0;
        wait_done(1, 200, "s1_done_timeout");
        check("s1_beats", acc_q.size(), 16);
        if (acc_q.size() == 16) begin
            check("s1_l_beat0", acc_q[0].l, 32'h03020100);
            check("s1_l_beat1", acc_q[1].l, 32'h07060504);
            check("s1_l_beat2", acc_q[2].l, 32'h0B0A0908);
            check("s1_l_beat3", acc_q[3].l, 32'h0F0E0D0C);
            check("s1_r_beat3", acc_q[3].r, 32'h0F0F0F0E);
            users = 0;
            last_mask = '0;
            for (int i = 0; i < 16; i++) begin
                users += int'(acc_q[i].user);
                last_mask[i] = acc_q[i].last;
            end
            check("s1_tuser_beat0", acc_q[0].user, 1);
            check("s1_tuser_count", users, 1);
            check("s1_tlast_mask", last_mask, 16'h8888);
            check("s1_beat_gap", acc_q[1].cyc - acc_q[0].cyc, 1);
            for (int l = 1; l < 4; l++) check("s1_line_gap", acc_q[l*4].cyc - acc_q[l*4-1].cyc, 3);
            check("s1_done_timing", done_cyc - acc_q[15].cyc, 1);
        end
        check("s1_frame_cnt", frame_cnt, 1);
        check("s1_model", beat_err, 0);

        // Random right-ready stalls, then both readies random with pattern_sel changing mid-frame.
        do_reset();
        pat = $urandom_range(0, 3);
        pattern_sel = 2'(pat); exp_pat = pat; enable = 1'b1;
        tick();
        enable = 1'b0;
        n = 0;
        while (done_cnt < 1 && n < 600) begin
            r_tready = 1'($urandom);
            tick();
            n++;
        end
        r_tready = 1'b1;
        check("s2_done1", done_cnt, 1);
        check("s2_beats1", acc_q.size(), 16);
        pat2 = $urandom_range(0, 3);
        pattern_sel = 2'(pat2); exp_pat = pat2; enable = 1'b1;
        n = 0;
        while (!l_tvalid && n < 20) begin
            tick();
            n++;
        end
        check("s2_restart", l_tvalid, 1);
        enable = 1'b0;
        pattern_sel = ~2'(pat2);
        n = 0;
        while (done_cnt < 2 && n < 800) begin
            l_tready = 1'($urandom);
            r_tready = 1'($urandom);
            tick();
            n++;
        end
        l_tready = 1'b1; r_tready = 1'b1;
        check("s2_done2", done_cnt, 2);
        check("s2_beats2", acc_q.size(), 32);
        check("s2_model", beat_err, 0);
        check("s2_hold", stall_err, 0);

        // Enable dropped during line 1: frame finishes, block parks in IDLE.
        do_reset();
        pattern_sel = 2'd0; exp_pat = 0; enable = 1'b1;
        wait_beats(5, 60, "s3_line1_timeout");
        enable = 1'b0;
        wait_done(1, 200, "s3_done_timeout");
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            valid_seen += int'(l_tvalid);
        end
        check("s3_idle_after", valid_seen, 0);
        check("s3_done_pulses", done_cnt, 1);
        check("s3_frame_cnt", frame_cnt, 1);
        check("s3_beats", acc_q.size(), 16);
        check("s3_model", beat_err, 0);

        // One-cycle reset in line 2 abandons the frame; restart begins with tuser.
        do_reset();
        pattern_sel = 2'd0; exp_pat = 0; enable = 1'b1;
        wait_beats(10, 80, "s4_line2_timeout");
        aresetn = 1'b0;
        tick();
        check("s4_tvalid_after_rst", {l_tvalid, r_tvalid}, 0);
        check("s4_frame_cnt", frame_cnt, 0);
        check("s4_no_done", done_cnt, 0);
        aresetn = 1'b1;
        n0 = acc_q.size();
        wait_beats(n0 + 1, 20, "s4_restart_timeout");
        if (acc_q.size() > n0) begin
            check("s4_restart_tuser", acc_q[n0].user, 1);
            check("s4_restart_tdata", acc_q[n0].l, 32'h03020100);
        end
        wait_done(1, 200, "s4_done_timeout");
        enable = 1'b0;
        check("s4_frame_cnt_after", frame_cnt, 1);
        check("s4_model", beat_err, 0);

        // Pattern 3 over 256 frames: frame_cnt feeds the pattern and wraps.
        do_reset();
        pattern_sel = 2'd3; exp_pat = 3; enable = 1'b1;
        wait_done(255, 255 * 40, "s5_255_timeout");
        check("s5_frame_cnt_255", frame_cnt, 255);
        wait_done(256, 60, "s5_256_timeout");
        enable = 1'b0;
        check("s5_frame_cnt_wrap", frame_cnt, 0);
        for (int i = 0; i < 10; i++) tick();
        check("s5_beats", acc_q.size(), 256 * FB);
        if (acc_q.size() > FB) check("s5_frame1_beat0", acc_q[FB].l, 32'h04030201);
        check("s5_model", beat_err, 0);
        check("s5_hold", stall_err, 0);
    endtask

    task automatic big_seq();
        int n, errs, guard, y, k;
        logic [31:0] el, er;
        logic [7:0]  p80, p88;
        p80 = 8'h55;
        p88 = 8'h55;
        b_rstn = 1'b0; b_en = 1'b0;
        tick(); tick();
        b_rstn = 1'b1; b_en = 1'b1;
        guard = 0;
        while (!b_l_tvalid && guard < 20) begin
            tick();
            guard++;
        end
        b_en = 1'b0;
        n = 0;
        errs = 0;
        while (b_l_tvalid && n < 80000) begin
            y = n / BIG_BEATS;
            k = n % BIG_BEATS;
            el = exp_beat(2, 0, y, k, 0, BIG_W, BIG_DS);
            er = exp_beat(2, 0, y, k, 1, BIG_W, BIG_DS);
            if (b_l_tdata !== el || b_r_tdata !== er || b_r_tvalid !== 1'b1 ||
                b_l_tlast !== (k == BIG_BEATS - 1) || b_l_tuser !== (n == 0) ||
                b_r_tlast !== b_l_tlast || b_r_tuser !== b_l_tuser) errs++;
            if (n == 2) p80 = b_l_tdata[7:0];
            if (n == 8 * BIG_BEATS + 2) p88 = b_l_tdata[7:0];
            n++;
            tick();
        end
        check("big_frame_beats", n, BIG_BEATS * BIG_H);
        check("big_model", errs, 0);
        check("big_pixel_8_0", p80, 8'hFF);
        check("big_pixel_8_8", p88, 8'h00);
        check("big_frame_cnt", b_frame_cnt, 1);
        check("big_frame_done", b_frame_done, 1);
    endtask

    initial begin
        fork
            small_seq();
            big_seq();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
